spram_bank_pm: RTL and testbench
================================

# spram_bank_pm

Parametrised single-port RAM subsystem: NUM_BANKS SB_SPRAM256KA banks (16K x 32 each) behind one request/ready port, with a per-bank power-state controller. Each bank drops to STANDBY, then SLEEP, after programmable idle periods. It wakes automatically on access, stalling the requester for the wake time. It replaces the fixed single-bank wrapper as the data/program memory of sail-core and exports per-bank state for the power monitor.

## Interface
- NUM_BANKS, 2, number of banks (1..4)
- IDLE_STBY, 16, idle cycles before ACTIVE -> STANDBY (>=1)
- IDLE_SLEEP, 256, further idle cycles in STANDBY before STANDBY -> SLEEP (>=1)
- WAKE_SLEEP, 4, cycles from SLEEP deassert to first accepted access (>=1)
- CNT_W, 16, idle/wake counter width; IDLE_STBY, IDLE_SLEEP and WAKE_SLEEP must be < 2^CNT_W
- Derived: BANK_W = max(1, clog2(NUM_BANKS)); ADDR_W = 14 + BANK_W

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req  in  1  access request; addr, we, be and wdata must be held stable until ready
- we  in  1  1 = write, 0 = read
- be  in  4  byte-lane write enables (1 = write lane)
- addr  in  ADDR_W  word address; [ADDR_W-1:14] = bank, [13:0] = word
- wdata  in  32  write data
- ready  out  1  request accepted this cycle
- rvalid  out  1  read data valid (one pulse per accepted read)
- rdata  out  32  read data
- force_sleep  in  1  level; drives every idle bank to SLEEP immediately
- bank_state  out  2*NUM_BANKS  per-bank state, 00 ACTIVE, 01 STANDBY, 10 SLEEP, 11 WAKE

## Operation
- Out-of-range bank index (>= NUM_BANKS): ready = 1 in the same cycle, no RAM access. A read returns rvalid with rdata = 0.
- Per-bank FSM. Reset state is ACTIVE, with counter = 0.
  - ACTIVE: an access to this bank clears the counter. Otherwise the counter increments. When the counter reaches IDLE_STBY -> STANDBY (counter cleared). force_sleep with no access -> SLEEP.
  - STANDBY: STANDBY pin = 1. A request to this bank -> ACTIVE next cycle (not accepted this cycle). The counter increments; when it reaches IDLE_SLEEP -> SLEEP. force_sleep -> SLEEP.
  - SLEEP: SLEEP pin = 1, contents retained. A request to this bank with force_sleep = 0 -> WAKE (counter cleared).
  - WAKE: pins deasserted; the counter increments; when it reaches WAKE_SLEEP -> ACTIVE.
- ready = req AND target bank state is ACTIVE; the RAM is accessed in the same cycle.
- force_sleep overrides a pending request: a bank under force_sleep never leaves SLEEP, and the requester stalls.
- Chip-select is asserted only on the accepted cycle. POWEROFF is tied to 1.
- rdata is muxed by the bank index registered at acceptance. rdata holds its last value when rvalid = 0.

## Timing
- Reset values: ready 0, rvalid 0, rdata 0, bank_state all 00. Counters are cleared asynchronously.
- Read latency: rvalid is 1 cycle after the ready cycle. Back-to-back reads to an ACTIVE bank sustain 1 per cycle.
- Write: completes on the ready cycle, with no response pulse.
- Access from STANDBY: ready 1 cycle after req rises.
- Access from SLEEP: ready WAKE_SLEEP + 1 cycles after req rises (1 cycle SLEEP->WAKE, plus WAKE_SLEEP cycles in WAKE).
- An access in the same cycle the idle counter hits its threshold wins: the bank stays ACTIVE.
- Counters saturate and never wrap.
- Reset mid-wake or mid-access: all banks return to ACTIVE, and any pending rvalid is dropped.

## Structure
- Package spram_pm_pkg holds:
  - typedef enum logic [1:0] pm_state_t {PM_ACTIVE, PM_STANDBY, PM_SLEEP, PM_WAKE}
  - localparam BANK_WORDS = 16384
- Sub-module spram_pm_fsm: one per bank in a generate loop. It takes hit, req and force_sleep, and outputs state, standby, sleep and accept. The top level holds decode, the SB_SPRAM256KA instances, the rvalid/bank-index registers and the rdata mux.

## Test plan
- Write 0xDEADBEEF to addr 0x0005 with be = 1111, then read it back. Expect: ready on the first req cycle, rvalid 1 cycle later, rdata = 0xDEADBEEF.
- Write 0x11223344, then write 0xAABBCCDD with be = 0101, then read. Expect rdata = 0x11BB33DD.
- Idle for IDLE_STBY cycles: bank_state[1:0] = 01. Then read. Expect ready exactly 1 cycle after req and correct data.
- Idle for IDLE_STBY + IDLE_SLEEP cycles: state = 10. Then read. Expect state 11 for WAKE_SLEEP cycles, ready at WAKE_SLEEP + 1, and contents retained.
- Hold force_sleep with req pending to bank 1. Expect bank 1 in 10 and ready = 0. Release force_sleep. Expect the wake sequence, then ready.
- Assert rst during the WAKE state. Expect all outputs at reset values immediately; the next access is accepted in 1 cycle.

Source files
------------

// File: rtl/spram_pm_pkg.sv
// Shared types and constants for the banked SPRAM power-managed subsystem.
//   pm_state_t  : per-bank power state, encoding is exported on bank_state
//   BANK_WORDS  : words per SPRAM bank (16K x 32 built from two 16K x 16 cells)
//   WORD_W      : word-address width inside one bank
//   calc_bank_w : bank-index width, never less than one bit
package spram_pm_pkg;

  typedef enum logic [1:0] {
    PM_ACTIVE  = 2'b00,
    PM_STANDBY = 2'b01,
    PM_SLEEP   = 2'b10,
    PM_WAKE    = 2'b11
  } pm_state_t;

  localparam int BANK_WORDS = 16384;
  localparam int WORD_W     = $clog2(BANK_WORDS);

  function automatic int calc_bank_w(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

endpackage

// File: rtl/spram_bank_pm_if.sv
// Request/ready memory port between the requester (master) and the
// banked SPRAM subsystem (slave).
//   req/we/be/addr/wdata : request, held stable by the master until ready
//   ready                : request accepted this cycle
//   rvalid/rdata         : read response, one cycle after acceptance
interface spram_bank_pm_if #(
  parameter int ADDR_W = 15
);
  logic              req;
  logic              we;
  logic [3:0]        be;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              ready;
  logic              rvalid;
  logic [31:0]       rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/SB_SPRAM256KA.sv
// Behavioural model of the iCE40UP 16K x 16 single-port RAM cell; the
// vendor cell library supplies the real primitive in implementation.
//   ADDRESS/DATAIN/MASKWREN/WREN/CHIPSELECT : access, MASKWREN is per nibble
//   STANDBY/SLEEP/POWEROFF                  : power controls (POWEROFF low = off)
//   DATAOUT                                 : registered read data, holds otherwise
module SB_SPRAM256KA (
  input  logic [13:0] ADDRESS,
  input  logic [15:0] DATAIN,
  input  logic [3:0]  MASKWREN,
  input  logic        WREN,
  input  logic        CHIPSELECT,
  input  logic        CLOCK,
  input  logic        STANDBY,
  input  logic        SLEEP,
  input  logic        POWEROFF,
  output logic [15:0] DATAOUT
);

  logic [15:0] mem [0:16383];
  logic        live;

  assign live = CHIPSELECT && !STANDBY && !SLEEP && POWEROFF;

  always_ff @(posedge CLOCK) begin
    if (live) begin
      if (WREN) begin
        for (int i = 0; i < 4; i++) begin
          if (MASKWREN[i]) mem[ADDRESS][4*i +: 4] <= DATAIN[4*i +: 4];
        end
      end else begin
        DATAOUT <= mem[ADDRESS];
      end
    end
  end

endmodule

// File: rtl/spram_pm_fsm.sv
// Power-state controller for one SPRAM bank.
//   clk, rst     : clock, async active-high reset
//   hit          : current address decodes to this bank
//   req          : request valid
//   force_sleep  : level, pushes an idle bank into SLEEP and holds it there
//   state        : current power state
//   standby/sleep: SPRAM power pins
//   accept       : bank takes the access this cycle (drives chip-select)
//
// state      | meaning
// -----------+--------------------------------------------------------
// PM_ACTIVE  | powered, accepts accesses, counts idle cycles
// PM_STANDBY | STANDBY pin high, any request returns to ACTIVE
// PM_SLEEP   | SLEEP pin high, contents retained, request starts a wake
// PM_WAKE    | pins released, counting out the wake time
module spram_pm_fsm
  import spram_pm_pkg::*;
#(
  parameter int IDLE_STBY  = 16,
  parameter int IDLE_SLEEP = 256,
  parameter int WAKE_SLEEP = 4,
  parameter int CNT_W      = 16
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      hit,
  input  logic      req,
  input  logic      force_sleep,
  output pm_state_t state,
  output logic      standby,
  output logic      sleep,
  output logic      accept
);

  pm_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             access;

  assign access  = req && hit;
  // saturating increment so an oversized threshold can never wrap the count
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PM_ACTIVE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      PM_ACTIVE: begin
        // an access on the threshold cycle keeps the bank awake
        if (access) begin
          cnt_d = '0;
        end else if (force_sleep) begin
          state_d = PM_SLEEP;
          cnt_d   = '0;
        end else if (cnt_inc >= CNT_W'(IDLE_STBY)) begin
          state_d = PM_STANDBY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      PM_STANDBY: begin
        if (force_sleep) begin
          state_d = PM_SLEEP;
          cnt_d   = '0;
        end else if (access) begin
          state_d = PM_ACTIVE;
          cnt_d   = '0;
        end else if (cnt_inc >= CNT_W'(IDLE_SLEEP)) begin
          state_d = PM_SLEEP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      PM_SLEEP: begin
        if (access && !force_sleep) begin
          state_d = PM_WAKE;
          cnt_d   = '0;
        end
      end
      PM_WAKE: begin
        if (cnt_inc >= CNT_W'(WAKE_SLEEP)) begin
          state_d = PM_ACTIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = PM_ACTIVE;
        cnt_d   = '0;
      end
    endcase
  end

  assign state   = state_q;
  assign standby = (state_q == PM_STANDBY);
  assign sleep   = (state_q == PM_SLEEP);
  assign accept  = (state_q == PM_ACTIVE) && access;

endmodule

// File: rtl/spram_bank_pm.sv
// Banked SPRAM memory with per-bank idle power management.
//   clk, rst     : clock, async active-high reset
//   bus          : request/ready port (slave side), see spram_bank_pm_if
//   force_sleep  : level, sends every idle bank to SLEEP and holds it there
//   bank_state   : 2 bits per bank, 00 ACTIVE 01 STANDBY 10 SLEEP 11 WAKE
// Address bits [ADDR_W-1:14] pick the bank; indices past the last bank are
// acknowledged immediately without touching any RAM and read back as zero.
module spram_bank_pm
  import spram_pm_pkg::*;
#(
  parameter int NUM_BANKS  = 2,
  parameter int IDLE_STBY  = 16,
  parameter int IDLE_SLEEP = 256,
  parameter int WAKE_SLEEP = 4,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  spram_bank_pm_if.slave         bus,
  input  logic                   force_sleep,
  output logic [2*NUM_BANKS-1:0] bank_state
);

  localparam int BANK_W = calc_bank_w(NUM_BANKS);
  localparam int ADDR_W = WORD_W + BANK_W;

  logic [BANK_W-1:0]           bank_idx;
  logic [WORD_W-1:0]           word_idx;
  logic                        in_range;
  logic [NUM_BANKS-1:0]        hit, accept, pin_stby, pin_sleep;
  logic [NUM_BANKS-1:0][31:0]  dout;
  pm_state_t                   bank_st [NUM_BANKS];

  logic                        rd_fire;
  logic                        rvalid_q;
  logic                        rd_oor_q;
  logic [BANK_W-1:0]           rd_bank_q;
  logic [31:0]                 rdata_q;
  logic [31:0]                 rd_mux;

  assign bank_idx = bus.addr[ADDR_W-1:WORD_W];
  assign word_idx = bus.addr[WORD_W-1:0];
  // widened by one bit so the compare stays meaningful for power-of-two counts
  assign in_range = ({1'b0, bank_idx} < (BANK_W+1)'(NUM_BANKS));

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign hit[b] = in_range && (bank_idx == BANK_W'(b));

    spram_pm_fsm #(
      .IDLE_STBY  (IDLE_STBY),
      .IDLE_SLEEP (IDLE_SLEEP),
      .WAKE_SLEEP (WAKE_SLEEP),
      .CNT_W      (CNT_W)
    ) u_fsm (
      .clk         (clk),
      .rst         (rst),
      .hit         (hit[b]),
      .req         (bus.req),
      .force_sleep (force_sleep),
      .state       (bank_st[b]),
      .standby     (pin_stby[b]),
      .sleep       (pin_sleep[b]),
      .accept      (accept[b])
    );

    assign bank_state[2*b +: 2] = bank_st[b];

    // each byte lane maps onto two nibble write masks of one 16-bit cell
    SB_SPRAM256KA u_ram_lo (
      .ADDRESS    (word_idx),
      .DATAIN     (bus.wdata[15:0]),
      .MASKWREN   ({bus.be[1], bus.be[1], bus.be[0], bus.be[0]}),
      .WREN       (bus.we),
      .CHIPSELECT (accept[b]),
      .CLOCK      (clk),
      .STANDBY    (pin_stby[b]),
      .SLEEP      (pin_sleep[b]),
      .POWEROFF   (1'b1),
      .DATAOUT    (dout[b][15:0])
    );

    SB_SPRAM256KA u_ram_hi (
      .ADDRESS    (word_idx),
      .DATAIN     (bus.wdata[31:16]),
      .MASKWREN   ({bus.be[3], bus.be[3], bus.be[2], bus.be[2]}),
      .WREN       (bus.we),
      .CHIPSELECT (accept[b]),
      .CLOCK      (clk),
      .STANDBY    (pin_stby[b]),
      .SLEEP      (pin_sleep[b]),
      .POWEROFF   (1'b1),
      .DATAOUT    (dout[b][31:16])
    );
  end

  assign bus.ready = bus.req && (!in_range || (|accept));
  assign rd_fire   = bus.ready && !bus.we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q  <= 1'b0;
      rd_oor_q  <= 1'b0;
      rd_bank_q <= '0;
      rdata_q   <= '0;
    end else begin
      rvalid_q <= rd_fire;
      if (rd_fire) begin
        rd_bank_q <= bank_idx;
        rd_oor_q  <= !in_range;
      end
      if (rvalid_q) rdata_q <= rd_mux;
    end
  end

  always_comb begin
    rd_mux = '0;
    if (!rd_oor_q) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (rd_bank_q == BANK_W'(b)) rd_mux = dout[b];
      end
    end
  end

  // the cells may change DATAOUT while sleeping, so the last response is
  // kept locally and replayed whenever rvalid is low
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rvalid_q ? rd_mux : rdata_q;

endmodule

// File: tb/tb_spram_bank_pm.sv
module tb_spram_bank_pm;

  localparam int NUM_BANKS  = 3;
  localparam int IDLE_STBY  = 4;
  localparam int IDLE_SLEEP = 6;
  localparam int WAKE_SLEEP = 3;
  localparam int CNT_W      = 8;
  localparam int ADDR_W     = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       force_sleep = 1'b0;
  logic [5:0] bank_state;

  int n_tests = 0;
  int n_fail  = 0;
  int wake0_cnt = 0;
  int wake1_cnt = 0;

  spram_bank_pm_if #(.ADDR_W(ADDR_W)) bus_if ();

  spram_bank_pm #(
    .NUM_BANKS  (NUM_BANKS),
    .IDLE_STBY  (IDLE_STBY),
    .IDLE_SLEEP (IDLE_SLEEP),
    .WAKE_SLEEP (WAKE_SLEEP),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if),
    .force_sleep (force_sleep),
    .bank_state  (bank_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bank_state[1:0] == 2'b11) wake0_cnt++;
    if (bank_state[3:2] == 2'b11) wake1_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // lat = cycles between req rising and the ready cycle; returns #1 after the accepting edge
  task automatic do_acc(input logic w, input logic [15:0] a, input logic [3:0] b,
                        input logic [31:0] d, output int lat);
    lat = 0;
    @(posedge clk); #1;
    bus_if.req = 1'b1; bus_if.we = w; bus_if.addr = a; bus_if.be = b; bus_if.wdata = d;
    @(negedge clk);
    while (!bus_if.ready && lat < 50) begin
      lat++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus_if.req = 1'b0; bus_if.we = 1'b0;
  endtask

  task automatic do_write(input string tag, input logic [15:0] a, input logic [3:0] b,
                          input logic [31:0] d, input int exp_lat);
    int lat;
    do_acc(1'b1, a, b, d, lat);
    check_eq({tag, "_lat"}, lat, exp_lat);
    @(negedge clk);
    check_eq({tag, "_no_rvalid"}, {31'd0, bus_if.rvalid}, 32'd0);
  endtask

  task automatic do_read(input string tag, input logic [15:0] a, input logic [31:0] exp,
                         input int exp_lat);
    int lat;
    do_acc(1'b0, a, 4'h0, 32'h0, lat);
    check_eq({tag, "_lat"}, lat, exp_lat);
    @(negedge clk);
    check_eq({tag, "_rvalid"}, {31'd0, bus_if.rvalid}, 32'd1);
    check_eq({tag, "_rdata"}, bus_if.rdata, exp);
  endtask

  initial begin
    int lat;
    int w_start;
    bus_if.req = 1'b0; bus_if.we = 1'b0; bus_if.be = 4'h0;
    bus_if.addr = '0; bus_if.wdata = '0;

    #1;
    check_eq("rst_ready", {31'd0, bus_if.ready}, 32'd0);
    check_eq("rst_rvalid", {31'd0, bus_if.rvalid}, 32'd0);
    check_eq("rst_rdata", bus_if.rdata, 32'd0);
    check_eq("rst_state", {26'd0, bank_state}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // full write, read back, response holds after the pulse
    do_write("wr_full", 16'h0005, 4'hF, 32'hDEADBEEF, 0);
    do_read("rd_full", 16'h0005, 32'hDEADBEEF, 0);
    @(negedge clk);
    check_eq("rvalid_pulse", {31'd0, bus_if.rvalid}, 32'd0);
    check_eq("rdata_hold", bus_if.rdata, 32'hDEADBEEF);

    // byte-lane merge
    do_write("wr_base", 16'h0005, 4'hF, 32'h11223344, 0);
    do_write("wr_lanes", 16'h0005, 4'b0101, 32'hAABBCCDD, 0);
    do_read("rd_lanes", 16'h0005, 32'h11BB33DD, 0);
    do_write("wr_w6", 16'h0006, 4'hF, 32'h5A5A0001, 0);

    // back-to-back reads
    @(posedge clk); #1;
    bus_if.req = 1'b1; bus_if.we = 1'b0; bus_if.addr = 16'h0005;
    @(negedge clk);
    check_eq("b2b_ready0", {31'd0, bus_if.ready}, 32'd1);
    @(posedge clk); #1;
    bus_if.addr = 16'h0006;
    @(negedge clk);
    check_eq("b2b_ready1", {31'd0, bus_if.ready}, 32'd1);
    check_eq("b2b_rvalid0", {31'd0, bus_if.rvalid}, 32'd1);
    check_eq("b2b_rdata0", bus_if.rdata, 32'h11BB33DD);
    @(posedge clk); #1;
    bus_if.req = 1'b0;
    @(negedge clk);
    check_eq("b2b_rvalid1", {31'd0, bus_if.rvalid}, 32'd1);
    check_eq("b2b_rdata1", bus_if.rdata, 32'h5A5A0001);

    // ACTIVE -> STANDBY exactly after IDLE_STBY idle edges
    repeat (IDLE_STBY - 1) @(posedge clk);
    #1 check_eq("stby_before", {30'd0, bank_state[1:0]}, 32'd0);
    @(posedge clk);
    #1 check_eq("stby_enter", {30'd0, bank_state[1:0]}, 32'd1);
    do_read("rd_stby", 16'h0005, 32'h11BB33DD, 1);

    // STANDBY -> SLEEP after a further IDLE_SLEEP edges, then wake on read
    repeat (IDLE_STBY + IDLE_SLEEP - 1) @(posedge clk);
    #1 check_eq("sleep_before", {30'd0, bank_state[1:0]}, 32'd1);
    @(posedge clk);
    #1 check_eq("sleep_enter", {30'd0, bank_state[1:0]}, 32'd2);
    w_start = wake0_cnt;
    do_read("rd_sleep", 16'h0006, 32'h5A5A0001, WAKE_SLEEP + 1);
    check_eq("wake0_cycles", wake0_cnt - w_start, WAKE_SLEEP);

    // bank index 3 is out of range for three banks
    do_read("rd_oor", 16'hC005, 32'h0, 0);
    do_write("wr_oor", 16'hC005, 4'hF, 32'hFFFFFFFF, 0);

    // force_sleep holds a pending write to bank 1
    @(posedge clk); #1;
    force_sleep = 1'b1;
    bus_if.req = 1'b1; bus_if.we = 1'b1; bus_if.addr = 16'h4005;
    bus_if.be = 4'hF; bus_if.wdata = 32'hCAFEF00D;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("fs_ready", {31'd0, bus_if.ready}, 32'd0);
      check_eq("fs_bank1", {30'd0, bank_state[3:2]}, 32'd2);
    end
    check_eq("fs_bank0", {30'd0, bank_state[1:0]}, 32'd2);
    @(posedge clk); #1;
    force_sleep = 1'b0;
    w_start = wake1_cnt;
    lat = 0;
    @(negedge clk);
    while (!bus_if.ready && lat < 50) begin
      lat++;
      @(negedge clk);
    end
    check_eq("fs_release_lat", lat, WAKE_SLEEP + 1);
    check_eq("wake1_cycles", wake1_cnt - w_start, WAKE_SLEEP);
    @(posedge clk); #1;
    bus_if.req = 1'b0; bus_if.we = 1'b0;
    do_read("rd_bank1", 16'h4005, 32'hCAFEF00D, 0);
    do_read("rd_bank0_slp", 16'h0005, 32'h11BB33DD, WAKE_SLEEP + 1);

    // reset during WAKE
    @(posedge clk); #1 force_sleep = 1'b1;
    @(posedge clk); #1 force_sleep = 1'b0;
    check_eq("fs_pulse_all", {26'd0, bank_state}, 32'h2A);
    bus_if.req = 1'b1; bus_if.we = 1'b0; bus_if.addr = 16'h0005;
    @(posedge clk);
    #1 check_eq("pre_rst_wake", {30'd0, bank_state[1:0]}, 32'd3);
    #3;
    bus_if.req = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_ready", {31'd0, bus_if.ready}, 32'd0);
    check_eq("mid_rst_rvalid", {31'd0, bus_if.rvalid}, 32'd0);
    check_eq("mid_rst_rdata", bus_if.rdata, 32'd0);
    check_eq("mid_rst_state", {26'd0, bank_state}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    do_read("rd_after_rst", 16'h0005, 32'h11BB33DD, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
